// File: rtl/memory_arbiter_pkg.sv
// Shared types and defaults for the fetch/data SRAM arbiter.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE  = 2'd0,
        OWNER_FETCH = 2'd1,
        OWNER_DATA  = 2'd2
    } mem_owner_t;

    localparam int ADDR_WIDTH_DEFAULT      = 32;
    localparam int DATA_WIDTH_DEFAULT      = 32;
    localparam int MAX_DATA_STREAK_DEFAULT = 4;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundles the fetch port, data port and SRAM port seen by the arbiter.
interface memory_arbiter_if
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
);

    logic                      ifetch_req_valid;
    logic                      ifetch_req_ready;
    logic [ADDR_WIDTH-1:0]     ifetch_addr;
    logic                      ifetch_flush;
    logic                      ifetch_rsp_valid;
    logic [DATA_WIDTH-1:0]     ifetch_rsp_data;

    logic                      dmem_req_valid;
    logic                      dmem_req_ready;
    logic [ADDR_WIDTH-1:0]     dmem_addr;
    logic                      dmem_we;
    logic [DATA_WIDTH-1:0]     dmem_wdata;
    logic [DATA_WIDTH/8-1:0]   dmem_wstrb;
    logic                      dmem_rsp_valid;
    logic [DATA_WIDTH-1:0]     dmem_rsp_data;

    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic [DATA_WIDTH/8-1:0]   mem_wstrb;
    logic [DATA_WIDTH-1:0]     mem_rdata;

    // Arbiter side: takes both requesters and the SRAM read data.
    modport slave (
        input  ifetch_req_valid, ifetch_addr, ifetch_flush,
        input  dmem_req_valid, dmem_addr, dmem_we, dmem_wdata, dmem_wstrb,
        input  mem_rdata,
        output ifetch_req_ready, ifetch_rsp_valid, ifetch_rsp_data,
        output dmem_req_ready, dmem_rsp_valid, dmem_rsp_data,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output ifetch_req_valid, ifetch_addr, ifetch_flush,
        output dmem_req_valid, dmem_addr, dmem_we, dmem_wdata, dmem_wstrb,
        output mem_rdata,
        input  ifetch_req_ready, ifetch_rsp_valid, ifetch_rsp_data,
        input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_data,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

endinterface

// File: rtl/memory_arbiter.sv
// Cycle-by-cycle arbiter sharing one single-port SRAM between fetch and data,
// data-first with a starvation guard, routing one-cycle read data to its owner.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH      = ADDR_WIDTH_DEFAULT,
    parameter int DATA_WIDTH      = DATA_WIDTH_DEFAULT,
    parameter int MAX_DATA_STREAK = MAX_DATA_STREAK_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    memory_arbiter_if.slave     bus
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    logic [3:0]  streak_q, streak_d;
    mem_owner_t  owner_q, owner_d;
    logic        we_q, we_d;

    logic        force_fetch;
    logic        grant_data;
    logic        grant_fetch;

    // Grants are suppressed while reset is held so nothing reaches the SRAM.
    always_comb begin
        force_fetch = bus.ifetch_req_valid && (streak_q == STREAK_MAX);
        grant_data  = !rst && bus.dmem_req_valid && !force_fetch;
        grant_fetch = !rst && !grant_data && bus.ifetch_req_valid;
    end

    always_comb begin
        streak_d = streak_q;
        owner_d  = OWNER_NONE;
        we_d     = 1'b0;
        if (grant_data) begin
            owner_d = OWNER_DATA;
            we_d    = bus.dmem_we;
        end else if (grant_fetch) begin
            owner_d = OWNER_FETCH;
        end
        // The streak only measures data wins while fetch is actually waiting.
        if (!bus.ifetch_req_valid || grant_fetch) begin
            streak_d = 4'd0;
        end else if (grant_data && streak_q != STREAK_MAX) begin
            streak_d = streak_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q <= 4'd0;
            owner_q  <= OWNER_NONE;
            we_q     <= 1'b0;
        end else begin
            streak_q <= streak_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
        end
    end

    always_comb begin
        bus.ifetch_req_ready = grant_fetch;
        bus.dmem_req_ready   = grant_data;
        bus.mem_en           = 1'b0;
        bus.mem_we           = 1'b0;
        bus.mem_addr         = '0;
        bus.mem_wdata        = '0;
        bus.mem_wstrb        = '0;
        if (grant_data) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.dmem_we;
            bus.mem_addr  = bus.dmem_addr;
            bus.mem_wdata = bus.dmem_wdata;
            bus.mem_wstrb = bus.dmem_wstrb;
        end else if (grant_fetch) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.ifetch_addr;
        end
    end

    // A flush kills the fetch slot due now; the data port never backpressures.
    always_comb begin
        bus.ifetch_rsp_valid = 1'b0;
        bus.ifetch_rsp_data  = '0;
        bus.dmem_rsp_valid   = 1'b0;
        bus.dmem_rsp_data    = '0;
        case (owner_q)
            OWNER_FETCH: begin
                bus.ifetch_rsp_valid = !bus.ifetch_flush;
                bus.ifetch_rsp_data  = bus.mem_rdata;
            end
            OWNER_DATA: begin
                bus.dmem_rsp_valid = 1'b1;
                bus.dmem_rsp_data  = we_q ? '0 : bus.mem_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed and randomized checks of memory_arbiter against a cycle-level
// behavioural model of the arbitration rules and a reference memory image.
module tb_memory_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int MAXS  = 4;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    memory_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    memory_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_DATA_STREAK(MAXS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Behavioural single-port SRAM with byte enables and one-cycle read latency.
    logic [DW-1:0] sram [DEPTH];
    logic [DW-1:0] sram_rdata;

    assign bus.mem_rdata = sram_rdata;

    initial begin
        for (int i = 0; i < DEPTH; i++) sram[i] = 32'hA500_0000 | (i << 8) | i;
        sram_rdata = '0;
    end

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < DW/8; b++)
                    if (bus.mem_wstrb[b]) sram[bus.mem_addr[5:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end else begin
                sram_rdata <= sram[bus.mem_addr[5:0]];
            end
        end
    end

    // Reference model state: memory image, pending response, fetch losing run.
    logic [DW-1:0] ref_mem [DEPTH];
    bit            pend_fetch;
    bit            pend_data;
    logic [DW-1:0] pend_rdata;
    int            fetch_lost;
    int            last_grant;
    int            vectors;
    int            miscompares;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of requests, checks everything at the falling edge,
    // then advances the model to what the SRAM and arbiter owe next cycle.
    task automatic applyStimulus(input logic iv, input logic [31:0] ia, input logic fl,
                                 input logic dv, input logic [31:0] da, input logic we,
                                 input logic [31:0] wd, input logic [3:0] ws);
        int            g;
        logic [DW-1:0] exp_ird, exp_drd;
        bus.ifetch_req_valid = iv;
        bus.ifetch_addr      = ia;
        bus.ifetch_flush     = fl;
        bus.dmem_req_valid   = dv;
        bus.dmem_addr        = da;
        bus.dmem_we          = we;
        bus.dmem_wdata       = wd;
        bus.dmem_wstrb       = ws;
        @(negedge clk);
        if (rst) begin
            pend_fetch = 0;
            pend_data  = 0;
            fetch_lost = 0;
        end
        // Data first, unless fetch has already lost MAXS cycles in a row.
        if (rst) g = 0;
        else if (dv && !(iv && fetch_lost >= MAXS)) g = 2;
        else if (iv) g = 1;
        else g = 0;

        checkOutput("ifetch_req_ready", bus.ifetch_req_ready, g == 1);
        checkOutput("dmem_req_ready", bus.dmem_req_ready, g == 2);
        checkOutput("mem_en", bus.mem_en, g != 0);
        checkOutput("mem_we", bus.mem_we, (g == 2) && we);
        checkOutput("mem_addr", bus.mem_addr, (g == 2) ? da : (g == 1) ? ia : 32'h0);
        checkOutput("mem_wdata", bus.mem_wdata, (g == 2) ? wd : 32'h0);
        checkOutput("mem_wstrb", bus.mem_wstrb, (g == 2) ? ws : 4'h0);

        exp_ird = pend_fetch ? pend_rdata : '0;
        exp_drd = pend_data ? pend_rdata : '0;
        checkOutput("ifetch_rsp_valid", bus.ifetch_rsp_valid, pend_fetch && !fl);
        checkOutput("ifetch_rsp_data", bus.ifetch_rsp_data, exp_ird);
        checkOutput("dmem_rsp_valid", bus.dmem_rsp_valid, pend_data);
        checkOutput("dmem_rsp_data", bus.dmem_rsp_data, exp_drd);

        pend_fetch = (g == 1);
        pend_data  = (g == 2);
        if (g == 1) pend_rdata = ref_mem[ia[5:0]];
        else if (g == 2 && !we) pend_rdata = ref_mem[da[5:0]];
        else pend_rdata = '0;
        if (g == 2 && we)
            for (int b = 0; b < DW/8; b++)
                if (ws[b]) ref_mem[da[5:0]][8*b +: 8] = wd[8*b +: 8];
        fetch_lost = (g == 2 && iv) ? fetch_lost + 1 : 0;
        last_grant = g;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit          hiv, hdv, hwe, fl;
        logic [31:0] hia, hda, hwd;
        logic [3:0]  hws;

        vectors     = 0;
        miscompares = 0;
        pend_fetch  = 0;
        pend_data   = 0;
        pend_rdata  = '0;
        fetch_lost  = 0;
        last_grant  = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'hA500_0000 | (i << 8) | i;

        // Outputs must stay quiet under reset even with both ports requesting.
        rst = 1'b1;
        applyStimulus(1, 32'h10, 0, 1, 32'h20, 1, 32'h1234_5678, 4'hF);
        applyStimulus(1, 32'h10, 0, 1, 32'h20, 0, 32'h0, 4'h0);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] fetch-only reads");
        applyStimulus(1, 32'h10, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h11, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h12, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] data write then read");
        applyStimulus(0, 0, 0, 1, 32'h20, 1, 32'hDEAD_BEEF, 4'hF);
        applyStimulus(0, 0, 0, 1, 32'h20, 0, 32'h0, 4'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] partial byte write");
        applyStimulus(0, 0, 0, 1, 32'h20, 1, 32'h00AB_0000, 4'b0100);
        applyStimulus(0, 0, 0, 1, 32'h20, 0, 32'h0, 4'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] contention with starvation guard");
        for (int i = 0; i < 12; i++) applyStimulus(1, 32'h30, 0, 1, 32'h31, 0, 32'h0, 4'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] saturated streak with fetch dropping valid");
        for (int i = 0; i < 4; i++) applyStimulus(1, 32'h05, 0, 1, 32'h06, 0, 32'h0, 4'h0);
        applyStimulus(0, 0, 0, 1, 32'h06, 0, 32'h0, 4'h0);
        applyStimulus(1, 32'h05, 0, 1, 32'h07, 0, 32'h0, 4'h0);
        applyStimulus(1, 32'h05, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] flush of in-flight fetch");
        applyStimulus(1, 32'h11, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h12, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] reset during data read");
        applyStimulus(0, 0, 0, 1, 32'h20, 0, 32'h0, 4'h0);
        rst = 1'b1;
        applyStimulus(1, 32'h10, 0, 1, 32'h21, 0, 32'h0, 4'h0);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] randomized traffic");
        hiv = 0; hdv = 0; hwe = 0;
        hia = '0; hda = '0; hwd = '0; hws = '0;
        for (int i = 0; i < 400; i++) begin
            if (!hiv && $urandom_range(0, 3) != 0) begin
                hiv = 1;
                hia = $urandom_range(0, DEPTH - 1);
            end
            if (!hdv && $urandom_range(0, 3) != 0) begin
                hdv = 1;
                hda = $urandom_range(0, DEPTH - 1);
                hwe = $urandom_range(0, 1) == 1;
                hwd = hwe ? $urandom : 32'h0;
                hws = hwe ? 4'($urandom_range(0, 15)) : 4'h0;
            end
            fl = $urandom_range(0, 7) == 0;
            applyStimulus(hiv, hia, fl, hdv, hda, hwe, hwd, hws);
            if (last_grant == 1) hiv = 0;
            if (last_grant == 2) hdv = 0;
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
